bid_arbiter: RTL and testbench

BID_ARBITER -- requirements
Module: bid_arbiter

---
 rtl/arb_pkg.sv | 30 +++
 rtl/bid_arbiter_if.sv | 15 +
 rtl/bid_select.sv | 46 ++++
 rtl/bid_arbiter.sv | 104 ++++++++++
 tb/tb_bid_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants, FSM encoding and helpers for the bid arbiter.
package arb_pkg;

  localparam int BID_W        = 4;
  localparam int BAL_W        = 10;
  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_OWN   = 2'd2;
  localparam logic [1:0] ST_COOL  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [1:0]       idx;
    logic [BID_W-1:0] bid;
  } sel_t;

  // A bid must be non-zero and strictly covered by the balance.
  function automatic logic is_eligible(input logic r, input logic [BID_W-1:0] b,
                                       input logic [BAL_W-1:0] bal);
    return r && (b != {BID_W{1'b0}}) && (bal > {{(BAL_W-BID_W){1'b0}}, b});
  endfunction

  function automatic logic [N_DEF-1:0] onehot(input logic [1:0] idx);
    return {{(N_DEF-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/bid_arbiter_if.sv
// Bidder-side bus of the bid arbiter: requests, bids, balances and award outputs.
interface bid_arbiter_if import arb_pkg::*; #(parameter int N = N_DEF);

  logic [N-1:0]       req;
  logic [BID_W*N-1:0] bid;
  logic [BAL_W*N-1:0] balance;
  logic [N-1:0]       grant;
  logic [N-1:0]       owner;
  logic [1:0]         owner_id;
  logic [BID_W-1:0]   win_bid;

  modport master (output req, bid, balance, input grant, owner, owner_id, win_bid);
  modport slave  (input req, bid, balance, output grant, owner, owner_id, win_bid);

endinterface

// File: rtl/bid_select.sv
// Combinational winner selection: eligibility, highest bid, round-robin tie-break.
module bid_select import arb_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]       req_i,
  input  logic [BID_W*N-1:0] bid_i,
  input  logic [BAL_W*N-1:0] balance_i,
  input  logic [1:0]         rr_ptr_i,
  output sel_t               sel_o
);

  logic [N-1:0]     elig_s;
  logic [BID_W-1:0] max_bid_s;

  // Eligibility mask and the highest eligible bid.
  always_comb begin
    elig_s    = '0;
    max_bid_s = '0;
    for (int i = 0; i < N; i++) begin
      elig_s[i] = is_eligible(req_i[i], bid_i[BID_W*i +: BID_W], balance_i[BAL_W*i +: BAL_W]);
      if (elig_s[i] && (bid_i[BID_W*i +: BID_W] > max_bid_s)) begin
        max_bid_s = bid_i[BID_W*i +: BID_W];
      end else begin
        max_bid_s = max_bid_s;
      end
    end
  end

  // Scan from the far end back toward rr_ptr so the nearest tied bidder is written last.
  always_comb begin
    logic [1:0] idx_s;
    idx_s = 2'd0;
    sel_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s = rr_ptr_i + 2'(k);
      if (elig_s[idx_s] && (bid_i[BID_W*idx_s +: BID_W] == max_bid_s)) begin
        sel_o.valid = 1'b1;
        sel_o.idx   = idx_s;
        sel_o.bid   = max_bid_s;
      end else begin
        sel_o = sel_o;
      end
    end
  end

endmodule

// File: rtl/bid_arbiter.sv
// Sealed-bid arbiter: awards the bus to the highest eligible bidder for a bounded
// ownership window, followed by one cool-down cycle that advances the tie-break pointer.
module bid_arbiter import arb_pkg::*; #(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic           clk,
  input logic           rst_n,
  bid_arbiter_if.slave  bus
);

  // hold_cnt reads 0 in the GRANT cycle, so reaching MAX_HOLD-1 marks the last owned cycle.
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  logic [1:0]       state_q,    state_d;
  logic [1:0]       rr_ptr_q,   rr_ptr_d;
  logic [4:0]       hold_cnt_q, hold_cnt_d;
  logic [1:0]       owner_id_q, owner_id_d;
  logic [BID_W-1:0] win_bid_q,  win_bid_d;
  logic [N-1:0]     grant_q,    grant_d;
  logic [N-1:0]     owner_q,    owner_d;
  sel_t             sel_s;
  logic             release_s;

  bid_select #(.N(N)) u_sel (
    .req_i     (bus.req),
    .bid_i     (bus.bid),
    .balance_i (bus.balance),
    .rr_ptr_i  (rr_ptr_q),
    .sel_o     (sel_s)
  );

  assign release_s = !bus.req[owner_id_q] || (hold_cnt_q == HOLD_LAST);

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    owner_id_d = owner_id_q;
    win_bid_d  = win_bid_q;
    grant_d    = '0;
    owner_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_s.valid) begin
          state_d    = ST_GRANT;
          owner_id_d = sel_s.idx;
          win_bid_d  = sel_s.bid;
          hold_cnt_d = 5'd0;
          grant_d    = onehot(sel_s.idx);
          owner_d    = onehot(sel_s.idx);
        end else begin
          hold_cnt_d = 5'd0;
        end
      end
      ST_GRANT, ST_OWN: begin
        if (release_s) begin
          state_d    = ST_COOL;
          hold_cnt_d = 5'd0;
        end else begin
          state_d    = ST_OWN;
          hold_cnt_d = hold_cnt_q + 5'd1;
          owner_d    = onehot(owner_id_q);
        end
      end
      ST_COOL: begin
        state_d  = ST_IDLE;
        rr_ptr_d = owner_id_q + 2'd1;
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = 5'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      hold_cnt_q <= 5'd0;
      owner_id_q <= 2'd0;
      win_bid_q  <= '0;
      grant_q    <= '0;
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      owner_id_q <= owner_id_d;
      win_bid_q  <= win_bid_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.owner_id = owner_id_q;
  assign bus.win_bid  = win_bid_q;

endmodule

// File: tb/tb_bid_arbiter.sv
// Bench for bid_arbiter: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level model of the auction.
module tb_bid_arbiter;
  import arb_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n;

  bid_arbiter_if #(.N(N)) bif();

  bid_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bus, for how many cycles so far, and the tie-break start point.
  int         m_own    = -1;
  int         m_last   = 0;
  int         m_cycles = 0;
  int         m_ptr    = 0;
  bit         m_cool   = 1'b0;
  logic [3:0] m_elig   = 4'd0;
  logic [3:0] e_grant  = 4'd0;
  logic [3:0] e_owner  = 4'd0;
  logic [1:0] e_id     = 2'd0;
  logic [3:0] e_bid    = 4'd0;
  bit         prev_g   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_b(input int i, input bit r, input int b, input int bal);
    bif.req[i]              = r;
    bif.bid[4*i +: 4]       = 4'(b);
    bif.balance[10*i +: 10] = 10'(bal);
  endtask

  task automatic model_step();
    int best;
    int maxb;
    int idx;
    int b;
    int bal;
    for (int i = 0; i < 4; i++) begin
      b   = int'(bif.bid[4*i +: 4]);
      bal = int'(bif.balance[10*i +: 10]);
      m_elig[i] = (bif.req[i] == 1'b1) && (b != 0) && (bal > b);
    end
    e_grant = 4'd0;
    if (rst_n !== 1'b1) begin
      m_own = -1; m_cool = 1'b0; m_ptr = 0; m_cycles = 0;
      e_id = 2'd0; e_bid = 4'd0;
    end else if (m_own >= 0) begin
      if (bif.req[m_own] == 1'b0 || m_cycles == MAX_HOLD) begin
        m_last = m_own; m_own = -1; m_cool = 1'b1;
      end else begin
        m_cycles++;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
      m_ptr  = (m_last + 1) % 4;
    end else begin
      best = -1; maxb = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (m_elig[idx] && int'(bif.bid[4*idx +: 4]) > maxb) begin
          best = idx;
          maxb = int'(bif.bid[4*idx +: 4]);
        end
      end
      if (best >= 0) begin
        m_own = best; m_cycles = 1;
        e_grant = 4'(1 << best); e_id = 2'(best); e_bid = 4'(maxb);
      end
    end
    e_owner = (m_own >= 0) ? 4'(1 << m_own) : 4'd0;
  endtask

  // Per-cycle comparison against the model plus structural invariants.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("grant", bif.grant, e_grant);
      check("owner", bif.owner, e_owner);
      check("owner_id", bif.owner_id, e_id);
      check("win_bid", bif.win_bid, e_bid);
      check("grant_onehot", ($countones(bif.grant) <= 1), 1);
      check("owner_onehot", ($countones(bif.owner) <= 1), 1);
      check("grant_elig", bif.grant & ~m_elig, 0);
      if (prev_g) check("grant_pulse", bif.grant, 0);
      prev_g = |bif.grant;
    end
  end

  initial begin
    int cnt;
    rst_n = 1'b0; bif.req = '0; bif.bid = '0; bif.balance = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", bif.grant, 0);
    check("rst_owner", bif.owner, 0);
    check("rst_owner_id", bif.owner_id, 0);
    check("rst_win_bid", bif.win_bid, 0);

    // Single bidder held for 3 cycles.
    rst_n = 1'b1;
    set_b(0, 1'b1, 5, 750);
    @(negedge clk); check("single_grant", bif.grant, 4'b0001); check("single_own1", bif.owner, 4'b0001);
    @(negedge clk); check("single_g0", bif.grant, 0); check("single_own2", bif.owner, 4'b0001);
    @(negedge clk); check("single_own3", bif.owner, 4'b0001); bif.req[0] = 1'b0;
    @(negedge clk); check("single_cool", bif.owner, 0);
    @(negedge clk); check("single_id", bif.owner_id, 0); check("single_bid", bif.win_bid, 5);

    // Highest bid with a tie, then the pointer moves the tie-break.
    rst_n = 1'b0;
    set_b(0, 1'b1, 3, 750); set_b(1, 1'b1, 9, 750); set_b(2, 1'b1, 9, 750); set_b(3, 1'b1, 2, 750);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check("max_id", bif.owner_id, 1); check("max_bid", bif.win_bid, 9);
    check("max_grant", bif.grant, 4'b0010); bif.req[1] = 1'b0;
    @(negedge clk); check("max_cool", bif.owner, 0); bif.req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk); check("tie_id", bif.owner_id, 2); check("tie_grant", bif.grant, 4'b0100);
    bif.req = '0;
    repeat (2) @(negedge clk);

    // Ineligible bidders: balance equal to bid, and zero bid.
    set_b(0, 1'b1, 8, 8); set_b(1, 1'b1, 0, 750);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("inelig_grant", bif.grant, 0);
    end
    set_b(0, 1'b1, 8, 9);
    @(negedge clk); check("elig_grant", bif.grant, 4'b0001);
    bif.req = '0;
    repeat (2) @(negedge clk);

    // Hold limit with a continuously held request.
    set_b(0, 1'b1, 5, 750);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bif.owner == 4'b0001) cnt++;
      else if (cnt > 0) break;
    end
    check("hold_len", cnt, MAX_HOLD);
    @(negedge clk); check("hold_idle", bif.grant, 0);
    @(negedge clk); check("hold_regrant", bif.grant, 4'b0001);

    // Reset in the fourth owned cycle; pointer must return to 0.
    repeat (3) @(negedge clk);
    check("pre_rst_owner", bif.owner, 4'b0001);
    rst_n = 1'b0;
    set_b(0, 1'b1, 7, 750); set_b(1, 1'b1, 7, 750);
    @(negedge clk);
    check("mid_rst_grant", bif.grant, 0); check("mid_rst_owner", bif.owner, 0);
    check("mid_rst_id", bif.owner_id, 0); check("mid_rst_bid", bif.win_bid, 0);
    rst_n = 1'b1;
    @(negedge clk); check("post_rst_id", bif.owner_id, 0); check("post_rst_grant", bif.grant, 4'b0001);
    bif.req = '0;
    repeat (2) @(negedge clk);

    // Random traffic with sticky requests so ownership windows vary in length.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          set_b(i, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 1023)));
        end
      end
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
